// File: rtl/tow_match_ctrl_pkg.sv
// Shared types and constants for the tug-of-war match controller.
// State encodings are visible on state_o, so their values are fixed here.
package tow_pkg;

   typedef enum logic [2:0] {
      ST_INIT      = 3'd0,
      ST_WAIT      = 3'd1,
      ST_DARK      = 3'd2,
      ST_PLAY      = 3'd3,
      ST_GLOAT     = 3'd4,
      ST_MATCH_END = 3'd5
   } state_t;

   localparam logic [1:0] LED_ALL  = 2'b11;
   localparam logic [1:0] LED_OFF  = 2'b00;
   localparam logic [1:0] LED_PLAY = 2'b10;
   localparam logic [1:0] LED_WIN  = 2'b01;

   // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting left
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

   typedef struct packed {
      logic       clear;
      logic       leds_on;
      logic [1:0] led_control;
   } led_out_t;

   function automatic led_out_t led_decode(state_t s);
      led_out_t o;
      o = '{clear: 1'b1, leds_on: 1'b1, led_control: LED_ALL};
      case (s)
         ST_DARK:      o = '{clear: 1'b0, leds_on: 1'b0, led_control: LED_OFF};
         ST_PLAY:      o = '{clear: 1'b0, leds_on: 1'b1, led_control: LED_PLAY};
         ST_GLOAT:     o = '{clear: 1'b1, leds_on: 1'b1, led_control: LED_PLAY};
         ST_MATCH_END: o = '{clear: 1'b1, leds_on: 1'b1, led_control: LED_WIN};
         default:      o = '{clear: 1'b1, leds_on: 1'b1, led_control: LED_ALL};
      endcase
      return o;
   endfunction

endpackage

// File: rtl/tow_match_ctrl_if.sv
// Bundle between the match controller (master) and the datapath/LED side (slave).
interface tow_match_ctrl_if #(
   parameter int N_PLAYERS     = 2,
   parameter int ROUNDS_TO_WIN = 3
);
   localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
   localparam int SW = $clog2(ROUNDS_TO_WIN + 1);

   logic                    tick;
   logic                    winrnd;
   logic [PW-1:0]           win_player;
   logic [N_PLAYERS-1:0]    btn_press;
   logic                    clear;
   logic                    leds_on;
   logic [1:0]              led_control;
   logic                    false_start;
   logic [PW-1:0]           fs_player;
   logic [N_PLAYERS*SW-1:0] scores;
   logic                    match_over;
   logic [PW-1:0]           match_winner;
   logic [2:0]              state_o;

   modport master (
      input  tick, winrnd, win_player, btn_press,
      output clear, leds_on, led_control, false_start, fs_player,
             scores, match_over, match_winner, state_o
   );

   modport slave (
      output tick, winrnd, win_player, btn_press,
      input  clear, leds_on, led_control, false_start, fs_player,
             scores, match_over, match_winner, state_o
   );

endinterface

// File: rtl/tow_match_ctrl_lfsr8.sv
// Free-running 8-bit LFSR for dark-phase durations; the seed is non-zero so it never locks up.
module tow_lfsr8
   import tow_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] out
);

   always_ff @(posedge clk) begin
      if (!rst) out <= LFSR_SEED;
      else      out <= {out[6:0], ^(out & LFSR_TAPS)};
   end

endmodule

// File: rtl/tow_match_ctrl.sv
// Match sequencer: wait, random dark, play, gloat per round; first to ROUNDS_TO_WIN ends the match.
//
// state      | meaning
// INIT       | just out of reset, loads the wait timer
// WAIT       | all LEDs lit, counting WAIT_TICKS slow ticks
// DARK       | LEDs off for a random 1..DARK_MAX ticks; a press here is a false start
// PLAY       | pull in progress, waiting for the datapath's round winner
// GLOAT      | round result shown for GLOAT_TICKS ticks
// MATCH_END  | winner shown, held until reset
module tow_match_ctrl
   import tow_pkg::*;
#(
   parameter int N_PLAYERS     = 2,
   parameter int WAIT_TICKS    = 2,
   parameter int GLOAT_TICKS   = 2,
   parameter int DARK_MAX      = 8,
   parameter int ROUNDS_TO_WIN = 3
) (
   input  logic               clk,
   input  logic               rst,
   tow_match_ctrl_if.master   bus
);

   localparam int PW      = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
   localparam int DW      = $clog2(DARK_MAX);
   localparam int SW      = $clog2(ROUNDS_TO_WIN + 1);
   localparam int MAX_WG  = (WAIT_TICKS > GLOAT_TICKS) ? WAIT_TICKS : GLOAT_TICKS;
   localparam int CNT_MAX = (MAX_WG > DARK_MAX) ? MAX_WG : DARK_MAX;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [SW-1:0] WIN_SCORE  = SW'(ROUNDS_TO_WIN);
   localparam logic [CW-1:0] WAIT_LOAD  = CW'(WAIT_TICKS);
   localparam logic [CW-1:0] GLOAT_LOAD = CW'(GLOAT_TICKS);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [SW-1:0] score [N_PLAYERS];
   logic          false_start;
   logic [PW-1:0] fs_player;
   logic [PW-1:0] match_winner;

   logic [7:0]    lfsr;
   logic [CW-1:0] dark_load;
   logic          win_ok;
   logic          any_done;
   logic [PW-1:0] done_idx;
   logic [PW-1:0] fs_idx;
   logic          unused_lfsr_bits;
   led_out_t      leds;

   tow_lfsr8 u_lfsr (
      .clk (clk),
      .rst (rst),
      .out (lfsr)
   );

   // Low DW bits plus one gives 1..DARK_MAX, never a zero-length dark phase
   assign dark_load        = CW'(lfsr[DW-1:0]) + CNT_ONE;
   assign unused_lfsr_bits = ^lfsr;
   assign win_ok           = int'(bus.win_player) < N_PLAYERS;

   always_comb begin
      any_done = 1'b0;
      done_idx = '0;
      fs_idx   = '0;
      for (int i = N_PLAYERS - 1; i >= 0; i--) begin
         if (score[i] == WIN_SCORE) begin
            any_done = 1'b1;
            done_idx = PW'(i);
         end
         if (bus.btn_press[i]) fs_idx = PW'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= ST_INIT;
         cnt          <= '0;
         false_start  <= 1'b0;
         fs_player    <= '0;
         match_winner <= '0;
         for (int i = 0; i < N_PLAYERS; i++) score[i] <= '0;
      end else begin
         false_start <= 1'b0;
         case (state)
            ST_INIT: begin
               state <= ST_WAIT;
               cnt   <= WAIT_LOAD;
            end
            ST_WAIT: begin
               if (bus.tick) begin
                  if (cnt == CNT_ONE) begin
                     state <= ST_DARK;
                     cnt   <= dark_load;
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end
            end
            ST_DARK: begin
               if (bus.winrnd) begin
                  if (win_ok && score[bus.win_player] != WIN_SCORE)
                     score[bus.win_player] <= score[bus.win_player] + SW'(1);
                  state <= ST_GLOAT;
                  cnt   <= GLOAT_LOAD;
               end else if (|bus.btn_press) begin
                  false_start <= 1'b1;
                  fs_player   <= fs_idx;
                  state       <= ST_GLOAT;
                  cnt         <= GLOAT_LOAD;
               end else if (bus.tick) begin
                  if (cnt == CNT_ONE) state <= ST_PLAY;
                  else                cnt   <= cnt - CNT_ONE;
               end
            end
            ST_PLAY: begin
               if (bus.winrnd) begin
                  if (win_ok && score[bus.win_player] != WIN_SCORE)
                     score[bus.win_player] <= score[bus.win_player] + SW'(1);
                  state <= ST_GLOAT;
                  cnt   <= GLOAT_LOAD;
               end
            end
            ST_GLOAT: begin
               if (bus.tick) begin
                  if (cnt == CNT_ONE) begin
                     if (any_done) begin
                        state        <= ST_MATCH_END;
                        match_winner <= done_idx;
                     end else begin
                        state <= ST_DARK;
                        cnt   <= dark_load;
                     end
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end
            end
            ST_MATCH_END: state <= ST_MATCH_END;
            default:      state <= ST_INIT;
         endcase
      end
   end

   assign leds = led_decode(state);

   assign bus.clear        = leds.clear;
   assign bus.leds_on      = leds.leds_on;
   assign bus.led_control  = leds.led_control;
   assign bus.false_start  = false_start;
   assign bus.fs_player    = fs_player;
   assign bus.match_over   = (state == ST_MATCH_END);
   assign bus.match_winner = match_winner;
   assign bus.state_o      = state;

   for (genvar g = 0; g < N_PLAYERS; g++) begin : g_scores
      assign bus.scores[g*SW +: SW] = score[g];
   end

endmodule

// File: tb/tb_tow_match_ctrl.sv
// Self-checking bench: directed match scenarios plus randomized play against a round-level model.
module tb_tow_match_ctrl;

   localparam int NP = 2;
   localparam int RW = 3;
   localparam int WT = 2;
   localparam int GT = 2;
   localparam int DM = 8;
   localparam int SW = 2;

   localparam int M_INIT = 0, M_WAIT = 1, M_DARK = 2, M_PLAY = 3, M_GLOAT = 4, M_END = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   tow_match_ctrl_if #(.N_PLAYERS(2), .ROUNDS_TO_WIN(3)) bus ();
   tow_match_ctrl_if #(.N_PLAYERS(3), .ROUNDS_TO_WIN(3)) bus3 ();

   tow_match_ctrl #(.N_PLAYERS(2), .WAIT_TICKS(WT), .GLOAT_TICKS(GT), .DARK_MAX(DM),
                    .ROUNDS_TO_WIN(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

   tow_match_ctrl #(.N_PLAYERS(3), .WAIT_TICKS(WT), .GLOAT_TICKS(GT), .DARK_MAX(DM),
                    .ROUNDS_TO_WIN(RW)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit tick_force = 0;
   bit wp3_override = 0;
   bit last_tick = 0;

   // Round-level model: phase, ticks remaining in the phase, scores, latched outputs
   int         m_state = M_INIT;
   int         m_left = 0;
   int         m_sc [NP];
   bit         m_fs = 0;
   int         m_fsp = 0;
   int         m_mw = 0;
   logic [7:0] m_lfsr = 8'hA5;
   logic [7:0] m_dark_seed = 8'h00;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   function automatic int led_row(input int s);
      case (s)
         M_DARK:  return 4'b0000;
         M_PLAY:  return 4'b0110;
         M_GLOAT: return 4'b1110;
         M_END:   return 4'b1101;
         default: return 4'b1111;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic enter_dark();
      m_state     = M_DARK;
      m_dark_seed = m_lfsr;
      m_left      = int'(m_lfsr) % DM + 1;
   endtask

   task automatic award(input int wp);
      if (wp < NP && m_sc[wp] < RW) m_sc[wp]++;
      m_state = M_GLOAT;
      m_left  = GT;
   endtask

   task automatic model_update();
      bit any_win;
      if (!rst) begin
         m_state = M_INIT; m_left = 0; m_fs = 0; m_fsp = 0; m_mw = 0;
         for (int i = 0; i < NP; i++) m_sc[i] = 0;
         m_lfsr = 8'hA5;
         return;
      end
      m_fs = 0;
      case (m_state)
         M_INIT: begin m_state = M_WAIT; m_left = WT; end
         M_WAIT: if (bus.tick) begin
            m_left--;
            if (m_left == 0) enter_dark();
         end
         M_DARK: begin
            if (bus.winrnd) award(int'(bus.win_player));
            else if (bus.btn_press != 0) begin
               m_fs = 1;
               for (int i = NP - 1; i >= 0; i--) if (bus.btn_press[i]) m_fsp = i;
               m_state = M_GLOAT; m_left = GT;
            end else if (bus.tick) begin
               m_left--;
               if (m_left == 0) m_state = M_PLAY;
            end
         end
         M_PLAY: if (bus.winrnd) award(int'(bus.win_player));
         M_GLOAT: if (bus.tick) begin
            m_left--;
            if (m_left == 0) begin
               any_win = 0;
               for (int i = NP - 1; i >= 0; i--)
                  if (m_sc[i] == RW) begin any_win = 1; m_mw = i; end
               if (any_win) m_state = M_END;
               else enter_dark();
            end
         end
         default: ;
      endcase
      m_lfsr = lfsr_next(m_lfsr);
   endtask

   task automatic compare();
      int row;
      int packed_sc;
      row = led_row(m_state);
      packed_sc = 0;
      for (int i = 0; i < NP; i++) packed_sc += m_sc[i] << (i * SW);
      chk("state", int'(bus.state_o), m_state);
      chk("clear", int'(bus.clear), (row >> 3) & 1);
      chk("leds_on", int'(bus.leds_on), (row >> 2) & 1);
      chk("led_control", int'(bus.led_control), row & 3);
      chk("false_start", int'(bus.false_start), int'(m_fs));
      chk("fs_player", int'(bus.fs_player), m_fsp);
      chk("scores", int'(bus.scores), packed_sc);
      chk("match_over", int'(bus.match_over), int'(m_state == M_END));
      chk("match_winner", int'(bus.match_winner), m_mw);
   endtask

   task automatic step();
      bus.tick          = tick_force || (cyc % 4 == 3);
      bus3.tick         = bus.tick;
      bus3.winrnd       = bus.winrnd;
      bus3.btn_press    = {1'b0, bus.btn_press};
      bus3.win_player   = wp3_override ? 2'd3 : {1'b0, bus.win_player};
      last_tick         = bus.tick;
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare();
      cyc++;
      bus.winrnd    = 1'b0;
      bus.btn_press = '0;
      tick_force    = 0;
      wp3_override  = 0;
   endtask

   task automatic wait_state(input int s, input int budget, input string name);
      int g;
      g = 0;
      while (m_state != s && g < budget) begin step(); g++; end
      if (m_state != s) begin
         checks++; errors++;
         $display("FAIL %s: timeout, model in state %0d, wanted %0d", name, m_state, s);
      end
   endtask

   task automatic count_ticks_in(input int dut_state, output int n);
      int g;
      n = 0; g = 0;
      while (int'(bus.state_o) == dut_state && g < 400) begin
         step();
         if (last_tick) n++;
         g++;
      end
   endtask

   task automatic win(input int wp);
      bus.winrnd = 1'b1;
      bus.win_player = 1'(wp);
      step();
   endtask

   initial begin
      int n;
      for (int i = 0; i < NP; i++) m_sc[i] = 0;
      bus.tick = 0; bus.winrnd = 0; bus.win_player = '0; bus.btn_press = '0;
      bus3.tick = 0; bus3.winrnd = 0; bus3.win_player = '0; bus3.btn_press = '0;

      rst = 1'b0;
      repeat (3) step();
      chk("reset_state_lit", int'(bus.state_o), 0);
      chk("reset_scores_lit", int'(bus.scores), 0);
      chk("reset_lc_lit", int'(bus.led_control), 3);
      rst = 1'b1;

      step();
      chk("wait_entry_lit", int'(bus.state_o), 1);
      chk("wait_lc_lit", int'(bus.led_control), 3);
      count_ticks_in(1, n);
      chk("wait_ticks_lit", n, 2);
      chk("dark_entry_lit", int'(bus.state_o), 2);
      chk("dark_leds_lit", int'(bus.leds_on), 0);
      chk("dark_clear_lit", int'(bus.clear), 0);

      count_ticks_in(2, n);
      chk("dark_len", n, int'(m_dark_seed[2:0]) + 1);
      chk("play_entry_lit", int'(bus.state_o), 3);
      chk("play_lc_lit", int'(bus.led_control), 2);
      chk("play_clear_lit", int'(bus.clear), 0);

      win(1);
      chk("play_win_state_lit", int'(bus.state_o), 4);
      chk("play_win_score_lit", int'(bus.scores), 4);

      wait_state(M_DARK, 200, "to_dark_fs");
      bus.btn_press = 2'b10;
      step();
      chk("fs_pulse_lit", int'(bus.false_start), 1);
      chk("fs_player_lit", int'(bus.fs_player), 1);
      chk("fs_state_lit", int'(bus.state_o), 4);
      chk("fs_scores_lit", int'(bus.scores), 4);
      step();
      chk("fs_one_cycle_lit", int'(bus.false_start), 0);

      wait_state(M_DARK, 200, "to_dark_prio");
      bus.btn_press = 2'b11;
      tick_force = 1;
      win(0);
      chk("prio_score_lit", int'(bus.scores), 5);
      chk("prio_no_fs_lit", int'(bus.false_start), 0);
      chk("prio_state_lit", int'(bus.state_o), 4);
      count_ticks_in(4, n);
      chk("gloat_ticks_lit", n, 2);
      chk("gloat_exit_lit", int'(bus.state_o), 2);

      win(1);
      chk("p1_second_lit", int'(bus.scores), 9);
      wait_state(M_DARK, 200, "to_dark_p1");
      win(1);
      chk("p1_third_lit", int'(bus.scores), 13);
      wait_state(M_END, 200, "to_match_end");
      chk("end_state_lit", int'(bus.state_o), 5);
      chk("end_over_lit", int'(bus.match_over), 1);
      chk("end_winner_lit", int'(bus.match_winner), 1);
      chk("end_lc_lit", int'(bus.led_control), 1);
      win(0);
      chk("end_ignore_win_lit", int'(bus.scores), 13);

      rst = 1'b0; step(); rst = 1'b1;
      chk("rst_from_end_lit", int'(bus.state_o), 0);
      wait_state(M_DARK, 200, "build_a"); win(0);
      wait_state(M_DARK, 200, "build_b"); win(0);
      wait_state(M_DARK, 200, "build_c"); win(1);
      wait_state(M_PLAY, 300, "to_play_rst");
      chk("pre_rst_scores_lit", int'(bus.scores), 6);
      chk("pre_rst_state_lit", int'(bus.state_o), 3);
      rst = 1'b0; step(); rst = 1'b1;
      chk("mid_play_rst_state_lit", int'(bus.state_o), 0);
      chk("mid_play_rst_scores_lit", int'(bus.scores), 0);

      wait_state(M_DARK, 200, "to_dark_np3");
      wp3_override = 1;
      win(0);
      chk("np3_oob_state_lit", int'(bus3.state_o), 4);
      chk("np3_oob_scores_lit", int'(bus3.scores), 0);
      chk("np2_score_lit", int'(bus.scores), 1);

      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 149) != 0);
         bus.winrnd = ($urandom_range(0, 7) == 0);
         bus.win_player = 1'($urandom_range(0, 1));
         bus.btn_press = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         tick_force = ($urandom_range(0, 2) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
